// File: rtl/mod_n_counter_pkg.sv
// ---------------------------------------------------------------
// counter_pkg : shared moduli and binary-to-BCD helper
// Revision    : 1.0
// ---------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int SEC_MOD   = 60;
  localparam int MIN_MOD   = 60;
  localparam int HOUR_MOD  = 24;
  localparam int DAY12_MOD = 12;

  // Valid for 0..99; callers never pass anything larger.
  function automatic logic [7:0] bin2bcd8(input logic [7:0] bin);
    return {4'(bin / 8'd10), 4'(bin % 8'd10)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter_if.sv
// ---------------------------------------------------------------
// mod_n_counter_if : control/status bundle for one counter stage
// Revision         : 1.0
// ---------------------------------------------------------------
`default_nettype none

interface mod_n_counter_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic [7:0]       bcd;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output clr, load, load_val, en, up,
    input  q, bcd, tc, wrap, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output q, bcd, tc, wrap, load_err
  );
endinterface

`default_nettype wire

// File: rtl/mod_n_counter_bcd_digit_pair.sv
// ---------------------------------------------------------------
// bcd_digit_pair : tens/ones BCD register pair with step controls
// Revision       : 1.0
// ---------------------------------------------------------------
`default_nettype none

module bcd_digit_pair (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       set_i,
  input  logic [7:0] set_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] bcd_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (set_i) begin
      tens_d = set_val_i[7:4];
      ones_d = set_val_i[3:0];
    end else if (inc_i) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec_i) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign bcd_o = {tens_q, ones_q};

endmodule

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ---------------------------------------------------------------
// mod_n_counter : modulo-N up/down counter with BCD and cascade tc
// Revision      : 1.0
// ---------------------------------------------------------------
`default_nettype none

module mod_n_counter
  import counter_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 8
) (
  input  logic          clk_1Hz,
  input  logic          rst_n,
  mod_n_counter_if.slave cnt_if
);

  if ((MODULUS < 2) || (MODULUS > 100)) begin : g_bad_modulus
    $error("mod_n_counter: MODULUS must be within 2..100");
  end
  if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
    $error("mod_n_counter: WIDTH too small for MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [7:0]       MAX_BCD = bin2bcd8(8'(MODULUS - 1));

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             dig_clr, dig_set, dig_inc, dig_dec;
  logic [7:0]       dig_set_val;
  logic [7:0]       bcd_w;

  always_comb begin
    q_d         = q_q;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    dig_clr     = 1'b0;
    dig_set     = 1'b0;
    dig_inc     = 1'b0;
    dig_dec     = 1'b0;
    dig_set_val = 8'h00;
    if (cnt_if.clr) begin
      q_d     = '0;
      dig_clr = 1'b1;
    end else if (cnt_if.load) begin
      dig_set = 1'b1;
      // Out-of-range loads saturate so q stays inside 0..MODULUS-1.
      if (cnt_if.load_val <= MAX_VAL) begin
        q_d         = cnt_if.load_val;
        dig_set_val = bin2bcd8(8'(cnt_if.load_val));
      end else begin
        q_d         = MAX_VAL;
        dig_set_val = MAX_BCD;
        err_d       = 1'b1;
      end
    end else if (cnt_if.en) begin
      if (cnt_if.up) begin
        if (q_q == MAX_VAL) begin
          q_d     = '0;
          wrap_d  = 1'b1;
          dig_clr = 1'b1;
        end else begin
          q_d     = q_q + WIDTH'(1);
          dig_inc = 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          q_d         = MAX_VAL;
          wrap_d      = 1'b1;
          dig_set     = 1'b1;
          dig_set_val = MAX_BCD;
        end else begin
          q_d     = q_q - WIDTH'(1);
          dig_dec = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  bcd_digit_pair u_digits (
    .clk_i     (clk_1Hz),
    .rst_ni    (rst_n),
    .clr_i     (dig_clr),
    .set_i     (dig_set),
    .set_val_i (dig_set_val),
    .inc_i     (dig_inc),
    .dec_i     (dig_dec),
    .bcd_o     (bcd_w)
  );

  assign cnt_if.q        = q_q;
  assign cnt_if.bcd      = bcd_w;
  assign cnt_if.wrap     = wrap_q;
  assign cnt_if.load_err = err_q;
  assign cnt_if.tc       = cnt_if.en & (cnt_if.up ? (q_q == MAX_VAL) : (q_q == '0));

endmodule

`default_nettype wire
